// File: rtl/uart_rx_deframer_pkg.sv
// uart_rx_deframer_pkg: shared FSM state type and clock/baud constants for the UART receiver
package uart_rx_deframer_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD_SET [5] = '{9600, 19200, 38400, 57600, 115200};
  function automatic int unsigned tick_div(input int unsigned baud, input int unsigned os);
    return CLK_HZ / (baud * os);
  endfunction
endpackage

// File: rtl/uart_rx_deframer_if.sv
// uart_rx_deframer_if: received-byte valid/ready bus with error and overrun flags
interface uart_rx_deframer_if #(parameter int DATA_BITS = 8) ();
  logic [DATA_BITS-1:0] data;
  logic valid;
  logic ready;
  logic frame_err;
  logic parity_err;
  logic overrun;
  modport master (output data, valid, frame_err, parity_err, overrun, input ready);
  modport slave (input data, valid, frame_err, parity_err, overrun, output ready);
endinterface

// File: rtl/uart_rx_deframer_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs with configurable reset value
module sync_2ff #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampled UART receive deframer presenting bytes on a valid/ready bus
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter bit PARITY_EN = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_tick,
  input  logic rx,
  output logic busy,
  uart_rx_deframer_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  rx_state_e state, state_nx;
  logic [TW-1:0] tick_cnt, tick_nx;
  logic [BW-1:0] bit_cnt, bit_nx;
  logic [DATA_BITS-1:0] shreg, data_q;
  logic rx_s, armed, armed_nx, shift, par_sample, done, par_err;
  logic valid_q, ferr_q, perr_q, ovr_q;
  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));
  // FSM and counter registers; armed blocks re-triggering on a held-low (break) line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tick_cnt <= '0;
      bit_cnt <= '0;
      armed <= 1'b1;
    end else begin
      state <= state_nx;
      tick_cnt <= tick_nx;
      bit_cnt <= bit_nx;
      armed <= armed_nx;
    end
  // Next-state and sampling strobes; nothing moves without a tick
  always_comb begin
    state_nx = state;
    tick_nx = tick_cnt;
    bit_nx = bit_cnt;
    armed_nx = armed;
    shift = 1'b0;
    par_sample = 1'b0;
    done = 1'b0;
    if (rx_tick) begin
      tick_nx = tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          tick_nx = '0;
          armed_nx = armed | rx_s;
          state_nx = (armed && !rx_s) ? START : IDLE;
        end
        START: if (tick_cnt == HALF) begin
          tick_nx = '0;
          bit_nx = '0;
          state_nx = rx_s ? IDLE : DATA;
        end
        DATA: if (tick_cnt == LAST) begin
          tick_nx = '0;
          shift = 1'b1;
          bit_nx = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
          state_nx = (bit_cnt != BIT_LAST) ? DATA : PARITY_EN ? PARITY : STOP;
        end
        PARITY: if (tick_cnt == LAST) begin
          tick_nx = '0;
          par_sample = 1'b1;
          state_nx = STOP;
        end
        STOP: if (tick_cnt == LAST) begin
          tick_nx = '0;
          done = 1'b1;
          armed_nx = rx_s;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  // Shift register, parity capture and output holding register with sticky overrun
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg <= '0;
      par_err <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (shift) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (par_sample) par_err <= rx_s ^ (^shreg) ^ PARITY_ODD;
      if (valid_q && bus.ready) valid_q <= 1'b0;
      if (done && (!valid_q || bus.ready)) begin
        data_q <= shreg;
        ferr_q <= ~rx_s;
        perr_q <= par_err;
        valid_q <= 1'b1;
      end
      if (done && valid_q && !bus.ready) ovr_q <= 1'b1;
    end
  assign busy = state != IDLE;
  assign bus.data = data_q;
  assign bus.valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.parity_err = perr_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: randomized scoreboard bench for the UART receive deframer
module tb_uart_rx_deframer;
  localparam int OS = 16;
  typedef struct packed {logic fe; logic pe; logic [7:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_tick = 1'b0;
  logic rx = 1'b1;
  logic rx_p = 1'b1;
  logic ready = 1'b1;
  logic busy, busy_p;
  bit rnd_rdy = 1'b0;
  bit rdy_fix = 1'b1;
  bit hold = 1'b0;
  bit pend = 1'b0;
  bit ovr_exp = 1'b0;
  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  exp_t q[$];
  exp_t qp[$];
  uart_rx_deframer_if #(.DATA_BITS(8)) bus ();
  uart_rx_deframer_if #(.DATA_BITS(8)) bus_p ();
  assign bus.ready = ready;
  assign bus_p.ready = ready;
  uart_rx_deframer #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_tick(rx_tick), .rx(rx), .busy(busy), .bus(bus));
  uart_rx_deframer #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .OVERSAMPLE(OS)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx_tick(rx_tick), .rx(rx_p), .busy(busy_p), .bus(bus_p));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Even-parity error rule: total ones over data plus parity bit must be even
  function automatic bit par_model(input logic [7:0] d, input bit pb);
    return 1'(($countones(d) + int'(pb)) % 2);
  endfunction

  // Reference model of the output register: a frame finishing while an unaccepted byte waits is dropped
  task automatic push_exp(input bit p, input logic [7:0] d, input bit fe, input bit pe);
    exp_t e;
    e = '{fe: fe, pe: pe, d: d};
    if (p) qp.push_back(e);
    else if (hold && pend) ovr_exp = 1'b1;
    else begin
      q.push_back(e);
      pend = hold;
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!rx_tick);
    end
  endtask

  task automatic drive(input bit p, input bit b);
    #1;
    if (p) rx_p = b;
    else rx = b;
  endtask

  task automatic idle(input bit p, input int n);
    drive(p, 1'b1);
    wait_ticks(n);
  endtask

  task automatic send(input bit p, input logic [7:0] d, input bit stop, input bit pb);
    drive(p, 1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      drive(p, d[i]);
      wait_ticks(OS);
    end
    if (p) begin
      drive(p, pb);
      wait_ticks(OS);
    end
    drive(p, stop);
    wait_ticks(OS);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || qp.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 32'(q.size() + qp.size()), 32'd0);
  endtask

  // Tick and ready stimulus, changed just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    rx_tick = ($urandom_range(0, 2) == 0);
    ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  // Monitor: pops the scoreboard on every accepted byte of either receiver
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (rst_n && bus.valid && ready) begin
      if (q.size() == 0) check("rx_unexpected", 32'({bus.frame_err, bus.parity_err, bus.data}), 32'hFFFF);
      else check("rx_frame", 32'({bus.frame_err, bus.parity_err, bus.data}), 32'(q.pop_front()));
    end
    if (rst_n && bus_p.valid && ready) begin
      if (qp.size() == 0) check("rxp_unexpected", 32'({bus_p.frame_err, bus_p.parity_err, bus_p.data}), 32'hFFFF);
      else check("rxp_frame", 32'({bus_p.frame_err, bus_p.parity_err, bus_p.data}), 32'(qp.pop_front()));
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit pb;
    int c0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_errs", 32'({bus.frame_err, bus.parity_err}), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_busy", 32'({busy, busy_p}), 32'd0);
    check("rst_valid_p", 32'(bus_p.valid), 32'd0);
    rst_n = 1'b1;
    idle(0, 20);
    push_exp(0, 8'hA5, 0, 0);
    send(0, 8'hA5, 1, 0);
    idle(0, OS);
    c0 = busy_cnt;
    drive(0, 1'b0);
    wait_ticks(6);
    idle(0, 2 * OS);
    check("glitch_busy_pulse", 32'(busy_cnt > c0), 32'd1);
    check("glitch_idle", 32'(busy), 32'd0);
    push_exp(0, 8'h3C, 1, 0);
    send(0, 8'h3C, 0, 0);
    wait_ticks(40);
    check("break_wait_idle", 32'(busy), 32'd0);
    idle(0, OS);
    push_exp(0, 8'h96, 0, 0);
    send(0, 8'h96, 1, 0);
    idle(0, OS);
    push_exp(1, 8'h07, 0, par_model(8'h07, 1'b0));
    send(1, 8'h07, 1, 0);
    idle(1, OS);
    push_exp(1, 8'h07, 0, par_model(8'h07, 1'b1));
    send(1, 8'h07, 1, 1);
    idle(1, OS);
    push_exp(0, 8'h11, 0, 0);
    push_exp(0, 8'h22, 0, 0);
    send(0, 8'h11, 1, 0);
    send(0, 8'h22, 1, 0);
    idle(0, OS);
    drain();
    check("b2b_no_overrun", 32'(bus.overrun), 32'(ovr_exp));
    rnd_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      push_exp(0, d, 0, 0);
      send(0, d, 1, 0);
      idle(0, $urandom_range(0, 20));
    end
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      pb = 1'($urandom);
      push_exp(1, d, 0, par_model(d, pb));
      send(1, d, 1, pb);
      idle(1, $urandom_range(0, 20));
    end
    rnd_rdy = 1'b0;
    drain();
    rdy_fix = 1'b0;
    hold = 1'b1;
    repeat (2) @(posedge clk);
    push_exp(0, 8'h11, 0, 0);
    push_exp(0, 8'h22, 0, 0);
    send(0, 8'h11, 1, 0);
    send(0, 8'h22, 1, 0);
    idle(0, OS);
    check("hold_overrun", 32'(bus.overrun), 32'(ovr_exp));
    check("hold_data", 32'({bus.valid, bus.data}), 32'h111);
    hold = 1'b0;
    pend = 1'b0;
    rdy_fix = 1'b1;
    drain();
    check("overrun_sticky", 32'(bus.overrun), 32'(ovr_exp));
    drive(0, 1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1);
      wait_ticks(OS);
    end
    drive(0, 1'b1);
    wait_ticks(OS / 2);
    #3 rst_n = 1'b0;
    ovr_exp = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_outputs", 32'({bus.valid, bus.frame_err, bus.parity_err, bus.overrun, bus.data}), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(0, 20);
    push_exp(0, 8'h5A, 0, 0);
    send(0, 8'h5A, 1, 0);
    idle(0, OS);
    drain();
    check("final_overrun", 32'(bus.overrun), 32'(ovr_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
